// File: rtl/eth_fcs_checker.sv
// eth_fcs_checker: receive-side Ethernet FCS checker.
// Recomputes the reflected CRC-32 over every frame byte (FCS included), holds
// the last four bytes in a delay line so the FCS is never forwarded, and
// reports one status pulse per frame aligned with the last payload byte.
module eth_fcs_checker #(
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1522,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   output logic [7:0]       m_data,
   output logic             m_valid,
   output logic             m_sof,
   output logic             m_eof,
   output logic             frame_done,
   output logic             frame_good,
   output logic             fcs_err,
   output logic             runt_err,
   output logic             oversize_err,
   output logic             abort_err,
   output logic [CNT_W-1:0] frame_len
);

   localparam logic [31:0]      CRC_POLY  = 32'hEDB88320;
   localparam logic [31:0]      CRC_INIT  = 32'hFFFFFFFF;
   localparam logic [31:0]      CRC_RESID = 32'hDEBB20E3;
   localparam logic [CNT_W-1:0] MIN_L     = CNT_W'(MIN_FRAME_LEN);
   localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX_FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);
   localparam logic [CNT_W-1:0] CNT_FOUR  = CNT_W'(4);

   typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

   // One byte of the LSB-first CRC, unrolled into an XOR network.
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [31:0]      crc_q, crc_d, crc_in, crc_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, len_new;
   logic             orphan_q, orphan_d;
   logic             shift_en;
   logic [7:0]       dly_q [4];
   logic             crc_bad, runt_new, over_new;

   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d;
   logic             done_q, done_d, good_q, good_d, fcs_q, fcs_d;
   logic             runt_q, runt_d, over_q, over_d, abort_q, abort_d;
   logic [CNT_W-1:0] len_q, len_d;

   // Next-state, CRC, counter and registered-output decode for one accepted byte.
   always_comb begin
      crc_in   = rx_sof ? CRC_INIT : crc_q;
      crc_nxt  = crc_byte(crc_in, rx_data);
      cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
      len_new  = rx_sof ? CNT_ONE : cnt_inc;
      crc_bad  = (crc_nxt != CRC_RESID);
      runt_new = (len_new < MIN_L);
      over_new = (len_new > MAX_L);

      state_d   = state_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      orphan_d  = orphan_q;
      shift_en  = 1'b0;
      m_data_d  = m_data_q;
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
      done_d    = 1'b0;
      fcs_d     = 1'b0;
      runt_d    = 1'b0;
      over_d    = 1'b0;
      abort_d   = 1'b0;
      len_d     = '0;

      if (rx_valid) begin
         if (rx_sof) begin
            // A start byte always opens a new frame, cutting any frame in progress.
            orphan_d = 1'b0;
            shift_en = 1'b1;
            crc_d    = crc_nxt;
            cnt_d    = CNT_ONE;
            if (state_q != IDLE) begin
               done_d  = 1'b1;
               abort_d = 1'b1;
               len_d   = cnt_q;
            end
            if (rx_eof) begin
               // One-byte frame; if it also cut a frame, the single pulse
               // carries both the abort and the one-byte frame's flags.
               done_d  = 1'b1;
               fcs_d   = crc_bad;
               runt_d  = runt_new;
               over_d  = over_new;
               len_d   = len_new;
               state_d = IDLE;
            end else begin
               state_d = FILL;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  // Only the first orphan byte after a frame is reported.
                  if (!orphan_q) begin
                     done_d   = 1'b1;
                     abort_d  = 1'b1;
                     len_d    = '0;
                     orphan_d = 1'b1;
                  end
               end
               default: begin
                  shift_en = 1'b1;
                  crc_d    = crc_nxt;
                  cnt_d    = cnt_inc;
                  if (state_q == PASS) begin
                     m_valid_d = 1'b1;
                     m_data_d  = dly_q[3];
                     m_sof_d   = (cnt_q == CNT_FOUR);
                     m_eof_d   = rx_eof;
                  end
                  if (rx_eof) begin
                     done_d  = 1'b1;
                     fcs_d   = crc_bad;
                     runt_d  = runt_new;
                     over_d  = over_new;
                     len_d   = len_new;
                     state_d = IDLE;
                  end else if (state_q == FILL && cnt_q == CNT_THREE) begin
                     state_d = PASS;
                  end
               end
            endcase
         end
      end
      good_d = done_d & ~fcs_d & ~runt_d & ~over_d & ~abort_d;
   end

   // State, CRC, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         crc_q     <= CRC_INIT;
         cnt_q     <= '0;
         orphan_q  <= 1'b0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_sof_q   <= 1'b0;
         m_eof_q   <= 1'b0;
         done_q    <= 1'b0;
         good_q    <= 1'b0;
         fcs_q     <= 1'b0;
         runt_q    <= 1'b0;
         over_q    <= 1'b0;
         abort_q   <= 1'b0;
         len_q     <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         orphan_q  <= orphan_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_sof_q   <= m_sof_d;
         m_eof_q   <= m_eof_d;
         done_q    <= done_d;
         good_q    <= good_d;
         fcs_q     <= fcs_d;
         runt_q    <= runt_d;
         over_q    <= over_d;
         abort_q   <= abort_d;
         len_q     <= len_d;
      end
   end

   // Four-byte delay line; index 3 is the oldest byte and the next payload out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) dly_q[i] <= '0;
      end else if (shift_en) begin
         dly_q[0] <= rx_data;
         for (int i = 1; i < 4; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign m_data       = m_data_q;
   assign m_valid      = m_valid_q;
   assign m_sof        = m_sof_q;
   assign m_eof        = m_eof_q;
   assign frame_done   = done_q;
   assign frame_good   = good_q;
   assign fcs_err      = fcs_q;
   assign runt_err     = runt_q;
   assign oversize_err = over_q;
   assign abort_err    = abort_q;
   assign frame_len    = len_q;

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Testbench for eth_fcs_checker: table of frames plus hand-written corner
// sequences; payload bytes and status pulses are checked via scoreboard queues.
module tb_eth_fcs_checker;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       rx_data;
   logic             rx_valid, rx_sof, rx_eof;
   logic [7:0]       m_data;
   logic             m_valid, m_sof, m_eof;
   logic             frame_done, frame_good, fcs_err, runt_err, oversize_err, abort_err;
   logic [CNT_W-1:0] frame_len;

   eth_fcs_checker #(
      .MIN_FRAME_LEN(13),
      .MAX_FRAME_LEN(1522),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
      .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof),
      .frame_done(frame_done), .frame_good(frame_good), .fcs_err(fcs_err),
      .runt_err(runt_err), .oversize_err(oversize_err), .abort_err(abort_err),
      .frame_len(frame_len)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; logic s; logic e; } pl_t;
   typedef struct {
      logic good, fcs, runt, over, abort;
      logic [15:0] len;
      logic meof;
      bit   full;
   } st_t;
   typedef struct {
      int len; int pat; int flip; int gap;
      logic good, fcs, runt, over;
      string nm;
   } vec_t;

   pl_t        exp_pl[$];
   st_t        exp_st[$];
   logic [7:0] frm_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   vec_t       vt[9];
   logic [7:0] kvec[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   function automatic vec_t mk(input int len, input int pat, input int flip, input int gap,
                               input logic good, input logic fcs, input logic runt,
                               input logic over, input string nm);
      vec_t v;
      v.len = len; v.pat = pat; v.flip = flip; v.gap = gap;
      v.good = good; v.fcs = fcs; v.runt = runt; v.over = over; v.nm = nm;
      return v;
   endfunction

   // Frames of 4 bytes or fewer are raw bytes; longer ones get a correct FCS.
   task automatic build(input int len, input int pat, input int flip);
      logic [31:0] c;
      frm_q.delete();
      if (len <= 4) begin
         for (int i = 0; i < len; i++) frm_q.push_back(8'(i + 1));
      end else begin
         for (int i = 0; i < len - 4; i++) begin
            case (pat)
               0:       frm_q.push_back(8'h00);
               1:       frm_q.push_back(8'(i));
               default: frm_q.push_back(8'($urandom));
            endcase
         end
         c = 32'hFFFFFFFF;
         foreach (frm_q[i]) c = crc_step(c, frm_q[i]);
         c = ~c;
         frm_q.push_back(c[7:0]);
         frm_q.push_back(c[15:8]);
         frm_q.push_back(c[23:16]);
         frm_q.push_back(c[31:24]);
      end
      if (flip >= 0) frm_q[flip] = frm_q[flip] ^ 8'h08;
   endtask

   task automatic push_pl(input int n, input bit with_eof);
      pl_t p;
      for (int i = 0; i < n; i++) begin
         p.d = frm_q[i];
         p.s = (i == 0);
         p.e = with_eof && (i == n - 1);
         exp_pl.push_back(p);
      end
   endtask

   task automatic push_st(input logic good, input logic fcs, input logic runt, input logic over,
                          input logic abort, input int len, input logic meof, input bit full);
      st_t s;
      s.good = good; s.fcs = fcs; s.runt = runt; s.over = over; s.abort = abort;
      s.len = 16'(len); s.meof = meof; s.full = full;
      exp_st.push_back(s);
   endtask

   task automatic idle_cycle();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      rx_sof   = 1'($urandom);
      rx_eof   = 1'($urandom);
      @(posedge clk); #1;
   endtask

   // Drive the first n bytes of frm_q with random gaps; junk on sof/eof during gaps.
   task automatic drive(input bit do_sof, input bit do_eof, input int gap_pct, input int n);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < 3; g++)
            if ($urandom_range(0, 99) < gap_pct) idle_cycle();
         rx_valid = 1'b1;
         rx_data  = frm_q[i];
         rx_sof   = do_sof && (i == 0);
         rx_eof   = do_eof && (i == n - 1);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_sof"}, m_sof, 0);
      chk({tag, "_m_eof"}, m_eof, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_frame_good"}, frame_good, 0);
      chk({tag, "_fcs_err"}, fcs_err, 0);
      chk({tag, "_runt_err"}, runt_err, 0);
      chk({tag, "_oversize_err"}, oversize_err, 0);
      chk({tag, "_abort_err"}, abort_err, 0);
      chk({tag, "_frame_len"}, frame_len, 0);
   endtask

   // Output monitor: pops the scoreboard whenever the DUT produces a byte or status.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid) begin
            if (exp_pl.size() == 0) begin
               chk("unexpected_m_valid", {24'h0, m_data}, 32'hFFFFFFFF);
            end else begin
               pl_t p;
               p = exp_pl.pop_front();
               $display("payload byte %02h sof=%0b eof=%0b", m_data, m_sof, m_eof);
               chk("m_data", m_data, p.d);
               chk("m_sof", m_sof, p.s);
               chk("m_eof", m_eof, p.e);
            end
         end
         if (frame_done) begin
            if (exp_st.size() == 0) begin
               chk("unexpected_frame_done", {16'h0, frame_len}, 32'hFFFFFFFF);
            end else begin
               st_t s;
               s = exp_st.pop_front();
               $display("status len=%0d good=%0b fcs=%0b runt=%0b over=%0b abort=%0b",
                        frame_len, frame_good, fcs_err, runt_err, oversize_err, abort_err);
               chk("frame_good", frame_good, s.good);
               chk("abort_err", abort_err, s.abort);
               chk("frame_len", frame_len, s.len);
               chk("done_m_eof", m_eof, s.meof);
               chk("done_m_valid", m_valid, s.meof);
               if (s.full) begin
                  chk("fcs_err", fcs_err, s.fcs);
                  chk("runt_err", runt_err, s.runt);
                  chk("oversize_err", oversize_err, s.over);
               end
            end
         end
      end
   end

   // Watchdog: the run must end on its own even if the stimulus stalls.
   initial begin
      #1_000_000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: got timeout want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      int n;
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;

      //            len  pat flip gap good fcs runt over
      vt[0] = mk(  64,  0,  -1,  30, 1,   0,  0,   0, "zeros64_gaps");
      vt[1] = mk(  64,  0,  20,  30, 0,   1,  0,   0, "zeros64_flip");
      vt[2] = mk(  12,  1,  -1,  10, 0,   0,  1,   0, "len12_runt");
      vt[3] = mk(  13,  2,  -1,  10, 1,   0,  0,   0, "len13_min");
      vt[4] = mk(   5,  1,  -1,   0, 0,   0,  1,   0, "len5_onepayload");
      vt[5] = mk(   3,  1,  -1,   0, 0,   1,  1,   0, "len3_nofcs");
      vt[6] = mk(1522,  2,  -1,   0, 1,   0,  0,   0, "len1522_max");
      vt[7] = mk(1523,  2,  -1,   5, 0,   0,  0,   1, "len1523_over");
      vt[8] = mk(1600,  2,  -1,   0, 0,   0,  0,   1, "len1600_over");

      kvec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycle();

      // Orphan bytes before any sof: a single abort with length 0
      frm_q.delete();
      frm_q.push_back(8'hAA); frm_q.push_back(8'hBB); frm_q.push_back(8'hCC);
      push_st(0, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 3);
      repeat (3) idle_cycle();

      // Known-answer vector "123456789" + FCS
      frm_q.delete();
      for (int i = 0; i < 13; i++) frm_q.push_back(kvec[i]);
      push_pl(9, 1);
      push_st(1, 0, 0, 0, 0, 13, 1, 1);
      $display("frame kat_123456789 len=13");
      drive(1, 1, 0, 13);
      repeat (3) idle_cycle();

      // Table-driven frames
      for (int v = 0; v < 9; v++) begin
         build(vt[v].len, vt[v].pat, vt[v].flip);
         n = (vt[v].len > 4) ? vt[v].len - 4 : 0;
         push_pl(n, 1);
         push_st(vt[v].good, vt[v].fcs, vt[v].runt, vt[v].over, 0, vt[v].len, (n > 0), 1);
         $display("frame %s len=%0d", vt[v].nm, vt[v].len);
         drive(1, 1, vt[v].gap, vt[v].len);
         repeat (2) idle_cycle();
      end

      // Frame A cut after 30 bytes by the sof of good frame B
      build(64, 2, -1);
      push_pl(26, 0);
      push_st(0, 0, 0, 0, 1, 30, 0, 0);
      $display("frame abort_A len=30");
      drive(1, 0, 0, 30);
      build(64, 1, -1);
      push_pl(60, 1);
      push_st(1, 0, 0, 0, 0, 64, 1, 1);
      $display("frame after_abort_B len=64");
      drive(1, 1, 0, 64);
      repeat (2) idle_cycle();

      // sof and eof on the same byte, then orphans reported once
      frm_q.delete();
      frm_q.push_back(8'h55);
      push_st(0, 1, 1, 0, 0, 1, 0, 1);
      $display("frame one_byte len=1");
      drive(1, 1, 0, 1);
      idle_cycle();
      frm_q.delete();
      frm_q.push_back(8'h11); frm_q.push_back(8'h22);
      push_st(0, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 2);
      repeat (2) idle_cycle();

      // Reset pulsed at byte 40, then a clean frame
      build(64, 2, -1);
      push_pl(36, 0);
      $display("frame reset_cut len=40");
      drive(1, 0, 0, 40);
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      chk_idle_outputs("midreset");
      rst = 1'b0;
      idle_cycle();
      build(64, 0, -1);
      push_pl(60, 1);
      push_st(1, 0, 0, 0, 0, 64, 1, 1);
      $display("frame post_reset len=64");
      drive(1, 1, 20, 64);

      repeat (10) idle_cycle();
      chk("payload_left", exp_pl.size(), 0);
      chk("status_left", exp_st.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/eth_fcs_checker.md
Name: eth_fcs_checker

Overview:
Receive-side counterpart of the transmit FCS generator. Accepts a byte stream carrying a complete Ethernet frame (DA through FCS) and recomputes IEEE 802.3 CRC-32 over every byte including the trailing FCS. It strips the 4 FCS bytes and forwards only the payload bytes. At end of frame it emits a one-cycle status pulse: good, FCS error, runt, oversize or aborted. It sits between the RX MAC byte deframer and the RX buffer.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes including FCS; a shorter frame sets runt_err.
MAX_FRAME_LEN, 1522, maximum legal frame length in bytes including FCS; a longer frame sets oversize_err.
CNT_W, 16, width of the byte counter; the counter saturates at all-ones.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  8  frame byte
rx_valid  in  1  rx_data valid; gaps allowed, no backpressure
rx_sof  in  1  first byte of frame; qualified by rx_valid
rx_eof  in  1  last byte of frame (last FCS byte); qualified by rx_valid; may coincide with rx_sof
m_data  out  8  payload byte (FCS removed)
m_valid  out  1  m_data valid
m_sof  out  1  first payload byte
m_eof  out  1  last payload byte
frame_done  out  1  one-cycle status pulse
frame_good  out  1  valid with frame_done: CRC correct, length legal, not aborted
fcs_err  out  1  valid with frame_done
runt_err  out  1  valid with frame_done
oversize_err  out  1  valid with frame_done
abort_err  out  1  valid with frame_done: frame was cut by rx_sof or had no rx_sof
frame_len  out  CNT_W  valid with frame_done: byte count including FCS, saturating

Behaviour:
- Reset: every output is 0; the CRC register is 0xFFFFFFFF; the delay line is empty; the state is IDLE.
- CRC: reflected algorithm, LSB-first, polynomial 0xEDB88320, init 0xFFFFFFFF. Per byte: crc <= (crc>>8) ^ T[crc[7:0]^rx_data]. The table or an equivalent XOR network is acceptable; the result must be single-cycle per byte.
- The transmitter appends ~crc least-significant byte first. A correct frame therefore leaves the register at residue 0xDEBB20E3 after its last byte. The check compares the combinational next-CRC of the eof byte against 0xDEBB20E3.
- States:
  - IDLE: waiting for a start of frame.
  - FILL: fewer than 4 bytes are held.
  - PASS: 4 bytes are held; payload is flowing.
- Transitions:
  - IDLE -> FILL on an accepted byte with rx_sof. The CRC reloads from init and that byte is included; count = 1.
  - FILL -> PASS when the 4th byte is accepted.
  - FILL or PASS -> IDLE on rx_eof.
- rx_sof arriving in FILL or PASS without a prior rx_eof:
  - The current frame ends with frame_done=1, abort_err=1, frame_good=0; no m_eof is issued.
  - The sof byte starts a new frame in the same cycle.
- A byte arriving in IDLE without rx_sof is discarded. One frame_done with abort_err=1 and frame_len=0 is raised on the first such byte only; further orphan bytes are silently dropped until the next sof.
- Delay line: a 4-byte shift register. In PASS, each accepted byte pushes out the oldest held byte as payload. Bytes held at eof are the FCS and are discarded.
- Timing: all outputs are registered. A byte accepted at edge N drives the outputs for cycle N+1.
  - m_valid is high only on cycles following an edge that pushed out a payload byte. m_valid=0 on rx_valid gaps.
  - m_sof accompanies the first pushed byte of the frame (input byte 5 accepted).
  - m_eof accompanies the byte pushed by the eof byte.
- Status: frame_done and all status fields are asserted in the same cycle as m_eof. For frames of 4 bytes or fewer, they are asserted in the cycle after eof is accepted, with no payload output.
  - frame_good = !fcs_err & !runt_err & !oversize_err & !abort_err.
- Length: the counter increments per accepted byte and saturates at 2^CNT_W-1.
  - runt_err if count < MIN_FRAME_LEN.
  - oversize_err if count > MAX_FRAME_LEN.
  - Payload output continues regardless of length errors.
- rx_sof and rx_eof on the same byte: a 1-byte frame. Flags: runt_err=1, fcs_err=1, frame_len=1; no payload output.
- rx_eof with rx_valid=0 is ignored.
- Reset asserted mid-frame: all state clears immediately and no frame_done is issued for the interrupted frame.

Test Plan:
- Payload ASCII "123456789" followed by FCS 26 39 F4 CB (13 bytes), MIN_FRAME_LEN=13 -> m_data sequence 31..39 with m_sof on 0x31 and m_eof on 0x39. Status: frame_done=1, frame_good=1, frame_len=13.
- 60 zero bytes plus the correct FCS, with random rx_valid gaps -> exactly 60 m_valid bytes, frame_good=1, frame_len=64, status in the same cycle as m_eof.
- Same 64-byte frame with bit 3 of byte 20 flipped -> fcs_err=1, frame_good=0, and all 60 payload bytes still forwarded.
- Frame A of 30 bytes is interrupted by rx_sof of a correct 64-byte frame B -> A reports abort_err=1 with no m_eof. B reports frame_good=1 with its m_sof on the byte following A's last forwarded byte.
- A 3-byte frame, then a 1600-byte frame with correct FCS -> first: runt_err=1, fcs_err=1, no m_valid. Second: oversize_err=1, fcs_err=0, 1596 payload bytes.
- Reset pulsed at byte 40 of a frame, then a clean 64-byte frame -> no frame_done for the interrupted frame; the next frame reports frame_good=1, frame_len=64.
